fifo_ctrl_64x16: RTL and testbench
==================================

Name: fifo_ctrl_64x16

Overview:
Synchronous FIFO controller that sits directly upstream of the 64x16 RAM and drives its write and read ports.
- Converts push/pop requests into RAM enables and addresses.
- Tracks occupancy and produces full, empty, overflow and underflow status.
- Flags read-data validity so a consumer can sample the RAM data_out.

Parameters:
WIDTH, 16, data word width; must match the RAM word width.
DEPTH, 64, number of RAM entries.
ADDR_W, 6, pointer width; DEPTH == 2**ADDR_W.

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset; sampled on rising edge of clk
push  input  1  write request
din  input  WIDTH  write data
pop  input  1  read request
wr_enable  output  1  RAM write enable
wr_adress  output  ADDR_W  RAM write address
data_in  output  WIDTH  RAM write data; equals din combinationally
rd_enable  output  1  RAM read enable
rd_adress  output  ADDR_W  RAM read address
rd_valid  output  1  RAM data_out holds the popped word this cycle
full  output  1  count == DEPTH
empty  output  1  count == 0
count  output  ADDR_W+1  occupancy, range 0..DEPTH
overflow  output  1  one-cycle pulse: push rejected
underflow  output  1  one-cycle pulse: pop rejected

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high. All registers clear on the first rising edge with reset=1.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, rd_valid=0, overflow=0, underflow=0. RAM contents are not cleared by this block.
- Accept rules use the registered full/empty state:
  - push_ok = push & ~full
  - pop_ok = pop & ~empty
- RAM drive is combinational from current state:
  - wr_enable = push_ok, wr_adress = wr_ptr
  - rd_enable = pop_ok, rd_adress = rd_ptr
  - During reset both enables are forced to 0.
- Pointers: wr_ptr increments on push_ok and rd_ptr increments on pop_ok. Both wrap DEPTH-1 -> 0 by natural ADDR_W overflow.
- Count updates:
  - push_ok only: +1
  - pop_ok only: -1
  - both or neither: unchanged
- full and empty are registered and derived from the next count value, so they update in the same edge as count.
- Read latency: RAM data_out is valid one cycle after rd_enable. rd_valid is a register loaded with pop_ok, so it is high exactly one cycle after each accepted pop.
- Boundary conditions:
  - Empty with push & pop: push accepted, pop rejected; underflow pulses; count becomes 1.
  - Full with push & pop: pop accepted, push rejected; overflow pulses; count becomes DEPTH-1.
  - Push while full (no pop): no write, wr_ptr held, overflow=1 for one cycle.
  - Pop while empty (no push): no read, rd_ptr held, underflow=1 for one cycle; rd_valid stays 0.
  - Reset asserted mid-burst: the next edge clears all state and rd_valid drops, even if a pop was accepted in the previous cycle.
- No write-through: data pushed in cycle N is readable by a pop in cycle N+1 at the earliest.

Optional Feature:
Macro FIFO_ALMOST_FLAGS_EN.
- Defined: adds parameters AF_LEVEL (default 60) and AE_LEVEL (default 4), and registered outputs almost_full (count >= AF_LEVEL) and almost_empty (count <= AE_LEVEL). Both reset to almost_full=0, almost_empty=1 and update on the same edge as count.
- Undefined: those ports and parameters do not exist; all other behaviour is identical.

Decomposition:
- Shared package fifo_pkg holds:
  - FIFO_WIDTH=16, FIFO_DEPTH=64, FIFO_ADDR_W=6
  - AF_LEVEL and AE_LEVEL defaults
  - the count width constant FIFO_ADDR_W+1
- One natural sub-module, fifo_ptr: an ADDR_W-bit wrapping counter with synchronous reset and increment enable. It is instantiated twice, for the write and read pointers.
- Flag and count logic stays in the top module.

Test Plan:
- Reset, then idle 3 cycles -> empty=1, full=0, count=0, both RAM enables 0, no overflow or underflow.
- Push 0x0000..0x003F on 64 consecutive cycles -> wr_adress steps 0..63; full=1 and count=64 after the 64th edge; a 65th push gives overflow=1 for one cycle and wr_enable=0.
- From full, pop 64 times -> rd_adress steps 0..63; rd_valid is high one cycle after each pop; empty=1 after the last pop; a 65th pop gives underflow=1.
- With count=5, hold push and pop together for 10 cycles -> count stays 5; wr_ptr and rd_ptr each advance by 10.
- Fill to 64, pop 10, push 10 -> wr_adress wraps 63->0 and reaches 9; data popped afterward comes out in order.
- Push 3 words, assert reset for one cycle while pop=1 -> next edge gives count=0, empty=1, rd_valid=0, pointers 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared sizing constants for the 64x16 FIFO controller and its pointer counters.
// Almost-flag thresholds apply only when FIFO_ALMOST_FLAGS_EN is defined.
package fifo_pkg;
    localparam int FIFO_WIDTH    = 16;
    localparam int FIFO_DEPTH    = 64;
    localparam int FIFO_ADDR_W   = 6;
    localparam int FIFO_CNT_W    = FIFO_ADDR_W + 1;
    localparam int FIFO_AF_LEVEL = 60;
    localparam int FIFO_AE_LEVEL = 4;
endpackage

// File: rtl/fifo_ptr.sv
// Wrapping ADDR_W-bit pointer; advances one entry per enabled cycle.
// Latency: new value visible the cycle after i_inc; no backpressure, caller gates i_inc.
// Wrap from DEPTH-1 to 0 comes from natural binary overflow.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_ptr
);

    logic [ADDR_W-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + ADDR_W'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_ctrl_64x16.sv
// FIFO controller driving a 64x16 RAM: push/pop to RAM enables/addresses plus occupancy flags.
// Latency: RAM drive is combinational; status and rd_valid are registered one edge later.
// Backpressure: push rejected while full (overflow), pop rejected while empty (underflow);
// FIFO_ALMOST_FLAGS_EN adds almost_full/almost_empty.
module fifo_ctrl_64x16
    import fifo_pkg::*;
#(
    parameter int WIDTH  = FIFO_WIDTH,
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int ADDR_W = FIFO_ADDR_W
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    parameter int AF_LEVEL = FIFO_AF_LEVEL,
    parameter int AE_LEVEL = FIFO_AE_LEVEL
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [WIDTH-1:0]  din,
    input  logic              pop,
    output logic              wr_enable,
    output logic [ADDR_W-1:0] wr_adress,
    output logic [WIDTH-1:0]  data_in,
    output logic              rd_enable,
    output logic [ADDR_W-1:0] rd_adress,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    output logic              almost_full,
    output logic              almost_empty
`endif
);

    localparam int CNT_W = ADDR_W + 1;

    logic             w_push_ok;
    logic             w_pop_ok;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             r_empty;
    logic             r_rd_valid;
    logic             r_overflow;
    logic             r_underflow;

    // Accept decisions use registered flags; reset masks both RAM enables.
    assign w_push_ok = push & ~r_full  & ~reset;
    assign w_pop_ok  = pop  & ~r_empty & ~reset;

    always_comb begin
        w_cnt_nxt = r_count;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_cnt_nxt = r_count + CNT_W'(1);
            2'b01:   w_cnt_nxt = r_count - CNT_W'(1);
            default: w_cnt_nxt = r_count;
        endcase
    end

    fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_push_ok),
        .o_ptr (wr_adress)
    );

    fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_pop_ok),
        .o_ptr (rd_adress)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_count     <= w_cnt_nxt;
            r_full      <= (w_cnt_nxt == CNT_W'(DEPTH));
            r_empty     <= (w_cnt_nxt == '0);
            r_rd_valid  <= w_pop_ok;
            r_overflow  <= push & r_full;
            r_underflow <= pop & r_empty;
        end
    end

`ifdef FIFO_ALMOST_FLAGS_EN
    logic r_almost_full;
    logic r_almost_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            r_almost_full  <= (w_cnt_nxt >= CNT_W'(AF_LEVEL));
            r_almost_empty <= (w_cnt_nxt <= CNT_W'(AE_LEVEL));
        end
    end

    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
`endif

    assign wr_enable = w_push_ok;
    assign rd_enable = w_pop_ok;
    assign data_in   = din;
    assign rd_valid  = r_rd_valid;
    assign full      = r_full;
    assign empty     = r_empty;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_fifo_ctrl_64x16.sv
// Directed bench for fifo_ctrl_64x16 with a behavioural 64x16 RAM attached to its ports.
module tb_fifo_ctrl_64x16;

    logic        clk = 1'b0;
    logic        reset;
    logic        push;
    logic [15:0] din;
    logic        pop;
    logic        wr_enable;
    logic [5:0]  wr_adress;
    logic [15:0] data_in;
    logic        rd_enable;
    logic [5:0]  rd_adress;
    logic        rd_valid;
    logic        full;
    logic        empty;
    logic [6:0]  count;
    logic        overflow;
    logic        underflow;
`ifdef FIFO_ALMOST_FLAGS_EN
    logic        almost_full;
    logic        almost_empty;
`endif

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [64];
    logic [15:0] ram_dout;

    always #5 clk = ~clk;

    fifo_ctrl_64x16 dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .din       (din),
        .pop       (pop),
        .wr_enable (wr_enable),
        .wr_adress (wr_adress),
        .data_in   (data_in),
        .rd_enable (rd_enable),
        .rd_adress (rd_adress),
        .rd_valid  (rd_valid),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
`ifdef FIFO_ALMOST_FLAGS_EN
        ,
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    // RAM with one-cycle read latency, as seen downstream of the controller
    always @(posedge clk) begin
        if (wr_enable) mem[wr_adress] <= data_in;
        if (rd_enable) ram_dout <= mem[rd_adress];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic p, input logic [15:0] d, input logic q);
        reset = r;
        push  = p;
        din   = d;
        pop   = q;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 16'h0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 16'h1234, 1'b1);
        chk("rst_wr_en_forced", wr_enable, 0);
        chk("rst_rd_en_forced", rd_enable, 0);
        tick();
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        repeat (3) tick();
        chk("idle_empty", empty, 1);
        chk("idle_full", full, 0);
        chk("idle_count", count, 0);
        chk("idle_wr_en", wr_enable, 0);
        chk("idle_rd_en", rd_enable, 0);
        chk("idle_ovf", overflow, 0);
        chk("idle_udf", underflow, 0);
        chk("idle_rd_valid", rd_valid, 0);
`ifdef FIFO_ALMOST_FLAGS_EN
        chk("idle_almost_empty", almost_empty, 1);
        chk("idle_almost_full", almost_full, 0);
`endif

        // fill 0x0000..0x003F
        for (int i = 0; i < 64; i++) begin
            drive(1'b0, 1'b1, 16'(i), 1'b0);
            chk("fill_wr_en", wr_enable, 1);
            chk("fill_wr_addr", wr_adress, i);
            chk("fill_data_in", data_in, i);
            tick();
            chk("fill_count", count, i + 1);
        end
        chk("fill_full", full, 1);
        chk("fill_not_empty", empty, 0);
        drive(1'b0, 1'b1, 16'hDEAD, 1'b0);
        chk("push_full_wr_en", wr_enable, 0);
        tick();
        chk("push_full_ovf", overflow, 1);
        chk("push_full_count", count, 64);
        chk("push_full_wr_held", wr_adress, 0);
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        tick();
        chk("ovf_one_cycle", overflow, 0);

        // drain in order
        for (int i = 0; i < 64; i++) begin
            drive(1'b0, 1'b0, 16'h0, 1'b1);
            chk("drain_rd_en", rd_enable, 1);
            chk("drain_rd_addr", rd_adress, i);
            tick();
            chk("drain_rd_valid", rd_valid, 1);
            chk("drain_data", ram_dout, i);
            chk("drain_count", count, 63 - i);
        end
        chk("drain_empty", empty, 1);
        chk("drain_not_full", full, 0);
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        chk("pop_empty_rd_en", rd_enable, 0);
        tick();
        chk("pop_empty_udf", underflow, 1);
        chk("pop_empty_rd_valid", rd_valid, 0);
        chk("pop_empty_rd_held", rd_adress, 0);
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        tick();
        chk("udf_one_cycle", underflow, 0);

        // empty with push and pop together
        drive(1'b0, 1'b1, 16'hAAAA, 1'b1);
        chk("emp_pp_wr_en", wr_enable, 1);
        chk("emp_pp_rd_en", rd_enable, 0);
        tick();
        chk("emp_pp_count", count, 1);
        chk("emp_pp_udf", underflow, 1);
        chk("emp_pp_rd_valid", rd_valid, 0);
        chk("emp_pp_not_empty", empty, 0);
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        tick();
        chk("emp_pp_pop_valid", rd_valid, 1);
        chk("emp_pp_pop_data", ram_dout, 16'hAAAA);
        chk("emp_pp_pop_count", count, 0);

        // steady state at count=5, pointers start at 1
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 16'(16'h100 + i), 1'b0);
            tick();
        end
        chk("c5_count", count, 5);
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 1'b1, 16'(16'h105 + k), 1'b1);
            chk("c5_wr_addr", wr_adress, 6 + k);
            chk("c5_rd_addr", rd_adress, 1 + k);
            tick();
            chk("c5_count_hold", count, 5);
            chk("c5_rd_valid", rd_valid, 1);
            chk("c5_data", ram_dout, 16'h100 + k);
        end
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        chk("c5_wr_adv10", wr_adress, 16);
        chk("c5_rd_adv10", rd_adress, 11);

        // reset, then fill / partial drain / refill across the wrap
        drive(1'b1, 1'b0, 16'h0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        chk("rst2_count", count, 0);
        chk("rst2_wr_addr", wr_adress, 0);
        chk("rst2_rd_addr", rd_adress, 0);
        for (int i = 0; i < 64; i++) begin
            drive(1'b0, 1'b1, 16'(16'h200 + i), 1'b0);
            chk("wrap_fill_addr", wr_adress, i);
            tick();
        end
        chk("wrap_full", full, 1);
        drive(1'b0, 1'b1, 16'hBEEF, 1'b1);
        chk("full_pp_wr_en", wr_enable, 0);
        chk("full_pp_rd_en", rd_enable, 1);
        tick();
        chk("full_pp_ovf", overflow, 1);
        chk("full_pp_count", count, 63);
        chk("full_pp_not_full", full, 0);
        chk("full_pp_data", ram_dout, 16'h200);
        for (int j = 0; j < 9; j++) begin
            drive(1'b0, 1'b0, 16'h0, 1'b1);
            tick();
            chk("wrap_pop_data", ram_dout, 16'h201 + j);
        end
        chk("wrap_count54", count, 54);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 16'(16'h300 + i), 1'b0);
            chk("wrap_wr_addr", wr_adress, i);
            tick();
        end
        chk("wrap_refull", full, 1);
        chk("wrap_wr_end", wr_adress, 10);
        for (int i = 0; i < 64; i++) begin
            drive(1'b0, 1'b0, 16'h0, 1'b1);
            chk("wrap_rd_addr", rd_adress, (10 + i) % 64);
            tick();
            chk("wrap_order", ram_dout, (i < 54) ? (16'h20A + i) : (16'h300 + i - 54));
        end
        chk("wrap_empty", empty, 1);

        // reset mid-burst right after an accepted pop
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 16'(16'h400 + i), 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        tick();
        chk("pre_rst_valid", rd_valid, 1);
        chk("pre_rst_count", count, 2);
        drive(1'b1, 1'b0, 16'h0, 1'b1);
        chk("mid_rst_rd_en", rd_enable, 0);
        tick();
        chk("mid_rst_count", count, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_full", full, 0);
        chk("mid_rst_rd_valid", rd_valid, 0);
        chk("mid_rst_wr_addr", wr_adress, 0);
        chk("mid_rst_rd_addr", rd_adress, 0);
        chk("mid_rst_udf", underflow, 0);
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
